pwm: RTL and testbench

PWM -- requirements
Module: pwm

---
 rtl/pwm_pkg.sv | 15 +
 rtl/pwm_counter.sv | 22 ++
 rtl/pwm.sv | 58 +++++
 tb/tb_pwm.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM block: default counter width and period length.
`timescale 1ns/1ps

package pwm_pkg;

    localparam int PWM_WIDTH_DFLT = 8;
    localparam int PWM_WIDTH_MIN  = 2;
    localparam int PWM_WIDTH_MAX  = 16;

    // One PWM period spans every value of the WIDTH-bit counter.
    function automatic int unsigned period_len(input int unsigned width);
        return 32'd1 << width;
    endfunction

endpackage

// File: rtl/pwm_counter.sv
// Free-running WIDTH-bit period counter; wraps from all-ones to zero, cleared by sync reset.
`timescale 1ns/1ps

module pwm_counter
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pwm.sv
// Registered PWM generator: out is high while the period counter is below the effective duty.
// Define PWM_SHADOW_EN to double-buffer the duty so changes land only on period boundaries.
`timescale 1ns/1ps

module pwm
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic             out
);

    localparam int unsigned     PERIOD  = period_len(WIDTH);
    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(PERIOD - 1);

    if (WIDTH < PWM_WIDTH_MIN || WIDTH > PWM_WIDTH_MAX) begin : g_bad_width
        $error("pwm: WIDTH out of supported range 2..16");
    end

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] duty_eff;

    pwm_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .cnt (cnt)
    );

`ifdef PWM_SHADOW_EN
    // Load on the last count of a period so the next period starts with a stable duty.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_eff <= '0;
        end else if (cnt == CNT_MAX) begin
            duty_eff <= in;
        end
    end
`else
    always_comb begin
        duty_eff = in;
    end
`endif

    // Compare uses the pre-increment count, giving one clock of latency to out.
    always_ff @(posedge clk) begin
        if (rst) begin
            out <= 1'b0;
        end else begin
            out <= (cnt < duty_eff);
        end
    end

endmodule

// File: tb/tb_pwm.sv
// Directed bench for pwm at WIDTH=8; expectations follow PWM_SHADOW_EN when it is defined.
`timescale 1ns/1ps

module tb_pwm;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic         dout;

    pwm #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .in  (din),
        .out (dout)
    );

    always #1 clk = ~clk;

    int n_chk   = 0;
    int n_fail  = 0;
    int ph      = 0;
    int cnt_err = 0;
    int highs, first, last, o101, h;
    int ld, nxt_ld, win_in, hs;
    bit cst;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // One clock; ph is the bench's own idea of the counter after the edge.
    task automatic tick();
        logic r;
        r = rst;
        @(posedge clk);
        @(negedge clk);
        ph = r ? 0 : (ph + 1) % 256;
        if (dut.cnt !== W'(ph)) cnt_err++;
    endtask

    task automatic settle();
        tick();
        while (ph != 0) tick();
    endtask

    task automatic run_period(input int chg_at, input logic [W-1:0] chg_val,
                              output int hi, output int fst, output int lst, output int o_101);
        hi = 0; fst = -1; lst = -1; o_101 = -1;
        for (int i = 0; i < 256; i++) begin
            if (ph == chg_at) din = chg_val;
            tick();
            if (dout === 1'b1) begin
                hi++;
                if (fst < 0) fst = ph;
                lst = ph;
            end
            if (ph == 101) o_101 = (dout === 1'b1) ? 1 : 0;
        end
    endtask

    initial begin
        din = 8'h80;
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_cnt", int'(dut.cnt), 0);
            chk("rst_out", (dout === 1'b0) ? 0 : 1, 0);
        end
        cnt_err = 0;
        rst = 1'b0;
        tick();
        chk("rel_cnt", int'(dut.cnt), 1);
`ifdef PWM_SHADOW_EN
        chk("rel_out", (dout === 1'b1) ? 1 : 0, 0);
`else
        chk("rel_out", (dout === 1'b1) ? 1 : 0, 1);
`endif

        din = 8'h00;
        settle();
        h = 0;
        for (int i = 0; i < 1024; i++) begin
            tick();
            if (dout !== 1'b0) h++;
        end
        chk("zero_highs", h, 0);

        din = 8'h40;
        settle();
        for (int p = 0; p < 4; p++) begin
            run_period(-1, 8'h00, highs, first, last, o101);
            chk("mid_highs", highs, 64);
            chk("mid_first", first, 1);
            chk("mid_last", last, 64);
        end

        din = 8'hFF;
        settle();
        run_period(-1, 8'h00, highs, first, last, o101);
        chk("max_highs", highs, 255);
        chk("max_first", first, 1);
        chk("max_last", last, 255);
        chk("cnt_track_max", cnt_err, 0);

        din = 8'h20;
        settle();
        run_period(100, 8'hC0, highs, first, last, o101);
`ifdef PWM_SHADOW_EN
        chk("chg_cur_highs", highs, 32);
        chk("chg_out_101", o101, 0);
`else
        chk("chg_cur_highs", highs, 124);
        chk("chg_out_101", o101, 1);
`endif
        run_period(-1, 8'h00, highs, first, last, o101);
        chk("chg_next_highs", highs, 192);

        din = 8'h40;
        settle();
        while (ph != 50) tick();
        rst = 1'b1;
        tick();
        tick();
        chk("rst2_cnt", int'(dut.cnt), 0);
        chk("rst2_out", (dout === 1'b0) ? 0 : 1, 0);
        rst = 1'b0;
        tick();
        chk("rst2_rel_cnt", int'(dut.cnt), 1);
        settle();
        run_period(-1, 8'h00, highs, first, last, o101);
        chk("rst2_highs", highs, 64);

        din = 8'h00;
        settle();
        ld = 0; nxt_ld = 0; hs = 0; cst = 1'b1; win_in = 0;
        for (int s = 0; s < 50000; s++) begin
            din = W'(s / 500);
            if (ph == 0) begin
                win_in = int'(din);
                cst = 1'b1;
            end else if (int'(din) != win_in) begin
                cst = 1'b0;
            end
            if (ph == 255) nxt_ld = int'(din);
            tick();
            if (dout === 1'b1) hs++;
            if (ph == 0) begin
`ifdef PWM_SHADOW_EN
                chk("sweep_highs", hs, ld);
                ld = nxt_ld;
`else
                if (cst) chk("sweep_highs", hs, win_in);
`endif
                hs = 0;
            end
        end
        chk("cnt_track_end", cnt_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
